bcd_ascii_streamer: RTL and testbench
=====================================

// Module: bcd_ascii_streamer
// PURPOSE
//   Downstream of the binary-to-BCD converter: captures its packed BCD result
//   and streams it as ASCII decimal characters over a valid/ready byte
//   interface, typically into the UART transmitter. Suppresses leading zeros
//   and optionally terminates each number with CR LF.
// PARAMETERS
//   DIGITS        16  number of packed BCD digits on bcd_in (4 bits each)
//   SUPPRESS_ZERO  1  1 = drop leading '0' characters; the LSD is always sent
//   APPEND_CRLF    1  1 = send 0x0D, 0x0A after the last digit
// PORTS
//   clk       in   1          system clock, all logic on rising edge
//   rst_n     in   1          asynchronous active-low reset
//   bcd_in    in   4*DIGITS   packed BCD, digit 0 = bits [3:0] (least significant)
//   bcd_valid in   1          level from converter; a 0->1 edge requests a send
//   tx_data   out  8          ASCII byte to sink
//   tx_valid  out  1          tx_data holds a byte to transfer
//   tx_ready  in   1          sink accepts; transfer when tx_valid && tx_ready
//   busy      out  1          high from capture until final byte is accepted
//   err       out  1          sticky per number: a nibble > 9 was emitted as '?'
// BEHAVIOUR
//   Reset: state IDLE; tx_data=0, tx_valid=0, busy=0, err=0, edge register=0.
//   Edge detect: bcd_valid registered each cycle; start = bcd_valid & ~prev.
//   Upstream done may stay high indefinitely; only the rising edge counts.
//   States:
//   - IDLE: on start, latch bcd_in, idx<=DIGITS-1, err<=0, busy<=1;
//     -> SKIP if SUPPRESS_ZERO else -> LOAD. start while not IDLE is dropped.
//   - SKIP: one digit/cycle; if digit[idx]==0 and idx!=0, idx<=idx-1, stay;
//     else -> LOAD. Digit 0 is never skipped (value 0 sends "0").
//   - LOAD: tx_data<=ASCII(digit[idx]), tx_valid<=1 -> SEND.
//   - SEND: hold tx_data/tx_valid stable until tx_ready. On transfer:
//     idx!=0 -> idx<=idx-1, -> LOAD; idx==0 -> CR if APPEND_CRLF else FIN.
//   - CR / LF: present 0x0D then 0x0A with the same hold rule; LF -> FIN.
//   - FIN: tx_valid=0, busy<=0 -> IDLE (one cycle).
//   ASCII: digit 0..9 -> 0x30+digit; digit 10..15 -> 0x3F '?' and err<=1.
//   tx_valid drops for exactly one cycle (LOAD) between bytes; tx_valid never
//   falls without a transfer except via reset.
//   Latency: start edge -> first tx_valid = 2 cycles + number of skipped zeros.
//   Input captured once; bcd_in changes during busy have no effect.
//   err holds until next capture; busy low again in the cycle after FIN.
//   Reset mid-stream: all outputs to reset values immediately; partial number
//   abandoned; a still-high bcd_valid after reset is seen as a new edge.
//   idx width = clog2(DIGITS); idx never underflows.
// TESTING
//   1 bcd_in=0, edge -> bytes 0x30,0x0D,0x0A; busy low after LF; err=0.
//   2 bcd_in=0x12345, tx_ready=1 -> "12345\r\n"; first tx_valid 13 cycles
//     after edge (11 skips + 2).
//   3 bcd_in=all 9s (16 digits), tx_ready toggled every 3 cycles -> 16 x 0x39
//     then CR LF; tx_data stable while tx_valid && !tx_ready.
//   4 bcd_in=0x0A07 -> "?07"? no: leading digit 0xA non-zero -> 0x3F,0x30,0x37,
//     CR,LF; err=1 until next capture.
//   5 bcd_valid held high after first number -> exactly one number sent;
//     new edge while busy -> ignored, no second stream.
//   6 rst_n low after 3rd byte of "12345" -> tx_valid=0, busy=0 async; after
//     release with bcd_valid high -> full "12345\r\n" resent.

Source files
------------

// File: rtl/bcd_ascii_streamer.sv
// Streams a captured packed-BCD number as ASCII decimal bytes over valid/ready,
// with optional leading-zero suppression and CR LF termination.
module bcd_ascii_streamer #(
  parameter int DIGITS        = 16,
  parameter bit SUPPRESS_ZERO = 1'b1,
  parameter bit APPEND_CRLF   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, SKIP, LOAD, SEND, CR, LF, FIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                prev_q, prev_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic                start;
  logic [3:0]          cur_digit;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  assign start     = bcd_valid & ~prev_q;
  assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prev_d     = bcd_valid;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    err_d      = err_q;
    bcd_d      = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          idx_d   = IDX_W'(DIGITS - 1);
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SUPPRESS_ZERO ? SKIP : LOAD;
        end
      end
      SKIP: begin
        // The least significant digit is always sent, even when zero.
        if (cur_digit == 4'd0 && idx_q != '0) idx_d = idx_q - 1'b1;
        else                                  state_d = LOAD;
      end
      LOAD: begin
        tx_data_d  = to_ascii(cur_digit);
        tx_valid_d = 1'b1;
        if (cur_digit > 4'd9) err_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            state_d = LOAD;
          end else begin
            state_d = APPEND_CRLF ? CR : FIN;
          end
        end
      end
      CR, LF: begin
        // First cycle in the state loads the byte; afterwards hold until accepted.
        if (!tx_valid_q) begin
          tx_data_d  = (state_q == CR) ? 8'h0D : 8'h0A;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = (state_q == CR) ? LF : FIN;
        end
      end
      FIN: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      prev_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Captured number is pure data; it is only read after a capture.
  always_ff @(posedge clk) begin
    bcd_q <= bcd_d;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Directed bench for bcd_ascii_streamer: byte streams, latency, back-pressure,
// error flag, edge detection and mid-stream reset.
module tb_bcd_ascii_streamer;

  localparam int DIGITS = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*DIGITS-1:0] bcd_in;
  logic                bcd_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  int         viol   = 0;
  int         stalls = 0;
  logic       tog_en = 1'b0;
  int         tog_cnt = 0;

  bcd_ascii_streamer #(.DIGITS(DIGITS), .SUPPRESS_ZERO(1'b1), .APPEND_CRLF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Collect accepted bytes and watch that a stalled byte stays put.
  always @(posedge clk) begin
    if (rst_n) begin
      if (hold_pend && (tx_valid !== 1'b1 || tx_data !== hold_data)) viol++;
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
      hold_pend = tx_valid && !tx_ready;
      if (hold_pend) stalls++;
      hold_data = tx_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt  = 0;
        tx_ready = ~tx_ready;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic start_num(input logic [4*DIGITS-1:0] val, input bit keep_high);
    @(negedge clk);
    bcd_in    = val;
    bcd_valid = 1'b1;
    if (!keep_high) begin
      @(negedge clk);
      bcd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (busy !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    while (busy !== 1'b0 && c < budget) begin @(negedge clk); c++; end
    check({tag, "_in_time"}, 64'(c < budget), 64'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] got;
    check({tag, "_len"}, 64'(rxq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), 64'(got), 64'(expq[i]));
    end
  endtask

  initial begin
    int lat;
    int c;
    rst_n     = 1'b0;
    bcd_in    = '0;
    bcd_valid = 1'b0;
    tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero value sends a single '0'
    rxq.delete();
    start_num('0, 1'b0);
    wait_done("t1", 200);
    expq = '{8'h30, 8'h0D, 8'h0A};
    check_stream("t1");
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_err", 64'(err), 64'd0);

    // 12345 with latency from capture edge to first valid
    rxq.delete();
    @(negedge clk);
    bcd_in    = 64'h12345;
    bcd_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (tx_valid) break;
    end
    check("t2_latency", 64'(lat), 64'd13);
    @(negedge clk);
    bcd_valid = 1'b0;
    wait_done("t2", 200);
    expq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    check_stream("t2");

    // All nines under toggling back-pressure
    rxq.delete();
    viol    = 0;
    stalls  = 0;
    tog_cnt = 0;
    tog_en  = 1'b1;
    start_num({DIGITS{4'h9}}, 1'b0);
    wait_done("t3", 2000);
    tog_en = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    expq.delete();
    for (int i = 0; i < DIGITS; i++) expq.push_back(8'h39);
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
    check_stream("t3");
    check("t3_hold_stable", 64'(viol), 64'd0);
    check("t3_saw_stalls", 64'(stalls > 0), 64'd1);

    // Invalid nibble becomes '?' and raises err
    rxq.delete();
    start_num(64'h0A07, 1'b0);
    wait_done("t4", 200);
    expq = '{8'h3F, 8'h30, 8'h37, 8'h0D, 8'h0A};
    check_stream("t4");
    check("t4_err", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    check("t4_err_held", 64'(err), 64'd1);

    // Level held high sends once; new edge while busy is dropped
    rxq.delete();
    start_num(64'h7, 1'b1);
    @(negedge clk);
    check("t5_err_cleared", 64'(err), 64'd0);
    wait_done("t5a", 200);
    repeat (20) @(negedge clk);
    expq = '{8'h37, 8'h0D, 8'h0A};
    check_stream("t5a");
    bcd_valid = 1'b0;
    rxq.delete();
    start_num(64'h42, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_busy_mid", 64'(busy), 64'd1);
    bcd_valid = 1'b0;
    @(negedge clk);
    bcd_valid = 1'b1;
    bcd_in    = 64'h99;
    wait_done("t5b", 200);
    repeat (30) @(negedge clk);
    expq = '{8'h34, 8'h32, 8'h0D, 8'h0A};
    check_stream("t5b");
    check("t5_idle", 64'(busy), 64'd0);
    bcd_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset after the third byte, then full resend on the still-high level
    rxq.delete();
    start_num(64'h12345, 1'b1);
    c = 0;
    while (rxq.size() < 3 && c < 200) begin @(negedge clk); c++; end
    check("t6_three_bytes", 64'(rxq.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(tx_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_data", 64'(tx_data), 64'h00);
    @(negedge clk);
    @(negedge clk);
    rxq.delete();
    rst_n = 1'b1;
    wait_done("t6", 200);
    expq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    check_stream("t6");
    bcd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
